// File: rtl/ipdc_op_sequencer.sv
// Queues host op commands and issues them one at a time to ipdc, streaming load pixels
// and waiting for ipdc completion beats before the next op; reports done and sticky errors.
module ipdc_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_COUNT  = 64,
  parameter int DISP_BEATS = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  input  logic [2:0]  i_cmd_mode,
  output logic        o_cmd_ready,
  input  logic        i_pix_valid,
  input  logic [23:0] i_pix_data,
  output logic        o_pix_ready,
  output logic        o_op_valid,
  output logic [2:0]  o_op_mode,
  output logic        o_in_valid,
  output logic [23:0] o_in_data,
  input  logic        i_in_ready,
  input  logic        i_out_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_done_mode,
  output logic [1:0]  o_err,
  input  logic        i_err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PIX_COUNT) + 1;
  localparam int BW = $clog2(DISP_BEATS) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [2:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_cur_mode;
  logic [BW-1:0] r_exp;
  logic [PW-1:0] r_pix_cnt;
  logic [BW-1:0] r_beat_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_op_valid;
  logic [2:0]    r_op_mode;
  logic          r_done;
  logic [2:0]    r_done_mode;
  logic [1:0]    r_err;

  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_pix_acc;
  logic w_last_pix;
  logic w_beat;
  logic w_last_beat;
  logic w_timeout;
  logic w_spur;

  // Ready depends only on the registered count, so a full FIFO refuses a push even while popping.
  assign o_cmd_ready = (r_count < CW'(FIFO_DEPTH));
  assign w_push      = i_cmd_valid & o_cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && i_in_ready;

  assign w_load      = (r_state == S_LOAD);
  assign o_pix_ready = w_load & i_in_ready;
  assign o_in_valid  = w_load & i_pix_valid & i_in_ready;
  assign o_in_data   = o_in_valid ? i_pix_data : '0;
  assign w_pix_acc   = o_in_valid;
  assign w_last_pix  = w_pix_acc && (r_pix_cnt == PW'(PIX_COUNT - 1));

  assign w_beat      = (r_state == S_WAIT) && i_out_valid;
  assign w_last_beat = w_beat && ((r_beat_cnt + BW'(1)) == r_exp);
  // A beat in the same cycle always rescues the op from timing out.
  assign w_timeout   = (r_state == S_WAIT) && !i_out_valid && (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_spur      = i_out_valid && (r_state != S_WAIT);

  assign o_busy      = (r_state != S_IDLE) || (r_count != '0);
  assign o_op_valid  = r_op_valid;
  assign o_op_mode   = r_op_mode;
  assign o_done      = r_done;
  assign o_done_mode = r_done_mode;
  assign o_err       = r_err;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= i_cmd_mode;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cur_mode  <= '0;
      r_exp       <= '0;
      r_pix_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_to_cnt    <= '0;
      r_op_valid  <= 1'b0;
      r_op_mode   <= '0;
      r_done      <= 1'b0;
      r_done_mode <= '0;
      r_err       <= '0;
    end else begin
      r_op_valid  <= 1'b0;
      r_op_mode   <= '0;
      r_done      <= 1'b0;
      r_done_mode <= '0;
      r_err       <= (i_err_clr ? 2'b00 : r_err) | {w_spur, w_timeout};
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_mode <= r_fifo[r_rd_ptr];
            r_op_valid <= 1'b1;
            r_op_mode  <= r_fifo[r_rd_ptr];
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_beat_cnt <= '0;
          r_to_cnt   <= '0;
          r_pix_cnt  <= '0;
          if (r_cur_mode == 3'd0) begin
            r_state <= S_LOAD;
          end else begin
            r_exp   <= (r_cur_mode <= 3'd4) ? BW'(DISP_BEATS) : BW'(1);
            r_state <= S_WAIT;
          end
        end
        S_LOAD: begin
          if (w_last_pix) begin
            r_pix_cnt  <= '0;
            r_exp      <= BW'(1);
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
            r_state    <= S_WAIT;
          end else if (w_pix_acc) begin
            r_pix_cnt <= r_pix_cnt + PW'(1);
          end
        end
        S_WAIT: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
            r_to_cnt   <= '0;
          end else if (r_to_cnt != TW'(TIMEOUT)) begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
          if (w_last_beat || w_timeout) begin
            r_done      <= 1'b1;
            r_done_mode <= r_cur_mode;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipdc_op_sequencer.sv
// Directed bench for ipdc_op_sequencer: load, display ops, FIFO full, stalls, timeout, errors, reset.
module tb_ipdc_op_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd_mode;
  logic        o_cmd_ready;
  logic        i_pix_valid;
  logic [23:0] i_pix_data;
  logic        o_pix_ready;
  logic        o_op_valid;
  logic [2:0]  o_op_mode;
  logic        o_in_valid;
  logic [23:0] o_in_data;
  logic        i_in_ready;
  logic        i_out_valid;
  logic        o_busy;
  logic        o_done;
  logic [2:0]  o_done_mode;
  logic [1:0]  o_err;
  logic        i_err_clr;

  ipdc_op_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .i_cmd_mode(i_cmd_mode), .o_cmd_ready(o_cmd_ready),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
    .o_op_valid(o_op_valid), .o_op_mode(o_op_mode),
    .o_in_valid(o_in_valid), .o_in_data(o_in_data), .i_in_ready(i_in_ready),
    .i_out_valid(i_out_valid), .o_busy(o_busy), .o_done(o_done), .o_done_mode(o_done_mode),
    .o_err(o_err), .i_err_clr(i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  int          op_q[$];
  int          op_cyc_q[$];
  int          done_q[$];
  int          done_cyc_q[$];
  logic [23:0] px_q[$];
  int          viol = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always begin
    @(negedge i_clk);
    #3;
    if (o_op_valid) begin
      op_q.push_back(int'(o_op_mode));
      op_cyc_q.push_back(cyc);
    end
    if (o_done) begin
      done_q.push_back(int'(o_done_mode));
      done_cyc_q.push_back(cyc);
    end
    if (o_in_valid) begin
      px_q.push_back(o_in_data);
      if (!i_in_ready) viol++;
    end
  end

  task automatic clr_logs();
    op_q.delete(); op_cyc_q.delete(); done_q.delete(); done_cyc_q.delete(); px_q.delete();
    viol = 0;
  endtask

  task automatic push(input logic [2:0] m);
    @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = m;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_op(input int n, input string tag);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge i_clk);
      #4;
      if (op_q.size() >= n) ok = 1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int n, input string tag);
    bit ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge i_clk);
      #4;
      if (done_q.size() >= n) ok = 1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic send_beats(input int n);
    for (int b = 0; b < n; b++) begin
      @(negedge i_clk);
      i_out_valid = 1'b1;
    end
    @(negedge i_clk);
    i_out_valid = 1'b0;
  endtask

  // Feeds pixels base+k until 64 are taken, then returns the single completion beat.
  task automatic load_px(input logic [23:0] base, input bit toggle, output int pr_bad);
    int k = 0;
    pr_bad = 0;
    for (int c = 0; c < 400 && k < 64; c++) begin
      @(negedge i_clk);
      if (toggle) i_in_ready = (c % 2 == 0);
      i_pix_valid = 1'b1;
      i_pix_data  = base + 24'(k);
      #3;
      if (o_pix_ready !== i_in_ready) pr_bad++;
      if (o_in_valid) k++;
    end
    @(negedge i_clk);
    i_pix_valid = 1'b0;
    i_pix_data  = '0;
    i_in_ready  = 1'b1;
    i_out_valid = 1'b1;
    @(negedge i_clk);
    i_out_valid = 1'b0;
  endtask

  function automatic int order_errs(input logic [23:0] base);
    int e = 0;
    for (int i = 0; i < px_q.size(); i++)
      if (px_q[i] !== base + 24'(i)) e++;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pr_bad;
    int last_cyc;
    bit acc;
    int exp_modes[5];

    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_mode = '0; i_pix_valid = 1'b0;
    i_pix_data = '0; i_in_ready = 1'b1; i_out_valid = 1'b0; i_err_clr = 1'b0;
    repeat (3) @(negedge i_clk);
    #3;
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_op_valid", 32'(o_op_valid), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_pix_ready", 32'(o_pix_ready), 32'd0);
    check("rst_in_valid", 32'(o_in_valid), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Load op, pixels 0x00..0x3F
    clr_logs();
    push(3'd0);
    wait_op(1, "t1_op_seen");
    load_px(24'h000000, 1'b0, pr_bad);
    wait_done(1, "t1_done_seen");
    check("t1_op_cnt", 32'(op_q.size()), 32'd1);
    check("t1_op_mode", 32'(op_q[0]), 32'd0);
    check("t1_px_cnt", 32'(px_q.size()), 32'd64);
    check("t1_px_order", 32'(order_errs(24'h000000)), 32'd0);
    check("t1_done_mode", 32'(done_q[0]), 32'd0);
    check("t1_err", 32'(o_err), 32'd0);

    // Display ops 1,2,4 with 16 beats each
    repeat (3) @(negedge i_clk);
    clr_logs();
    push(3'd1); push(3'd2); push(3'd4);
    for (int i = 0; i < 3; i++) begin
      wait_op(i + 1, "t2_op_seen");
      send_beats(16);
    end
    wait_done(3, "t2_done_seen");
    check("t2_op_cnt", 32'(op_q.size()), 32'd3);
    check("t2_op0", 32'(op_q[0]), 32'd1);
    check("t2_op1", 32'(op_q[1]), 32'd2);
    check("t2_op2", 32'(op_q[2]), 32'd4);
    check("t2_done_cnt", 32'(done_q.size()), 32'd3);
    check("t2_done2", 32'(done_q[2]), 32'd4);
    check("t2_gap01", 32'(op_cyc_q[1] - done_cyc_q[0]), 32'd2);
    check("t2_gap12", 32'(op_cyc_q[2] - done_cyc_q[1]), 32'd2);
    check("t2_err", 32'(o_err), 32'd0);

    // FIFO full with ipdc stalled
    repeat (3) @(negedge i_clk);
    clr_logs();
    @(negedge i_clk);
    i_in_ready = 1'b0;
    exp_modes = '{5, 6, 7, 6, 5};
    for (int i = 0; i < 4; i++) push(3'(exp_modes[i]));
    #3;
    check("t3_full_ready", 32'(o_cmd_ready), 32'd0);
    @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = 3'(exp_modes[4]);
    repeat (5) @(negedge i_clk);
    #3;
    check("t3_still_full", 32'(o_cmd_ready), 32'd0);
    check("t3_no_op_stalled", 32'(op_q.size()), 32'd0);
    check("t3_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    i_in_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      #3;
      if (o_cmd_ready) acc = 1;
      @(negedge i_clk);
    end
    i_cmd_valid = 1'b0;
    check("t3_fifth_accepted", 32'(acc), 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_op(k + 1, "t3_op_seen");
      send_beats(1);
    end
    wait_done(5, "t3_done_seen");
    check("t3_op_cnt", 32'(op_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) check("t3_op_order", 32'(op_q[k]), 32'(exp_modes[k]));

    // Load with ipdc ready toggling
    repeat (3) @(negedge i_clk);
    clr_logs();
    push(3'd0);
    wait_op(1, "t4_op_seen");
    load_px(24'hA50000, 1'b1, pr_bad);
    wait_done(1, "t4_done_seen");
    check("t4_px_cnt", 32'(px_q.size()), 32'd64);
    check("t4_px_order", 32'(order_errs(24'hA50000)), 32'd0);
    check("t4_pix_ready_follow", 32'(pr_bad), 32'd0);
    check("t4_no_xfer_stalled", 32'(viol), 32'd0);
    check("t4_done_mode", 32'(done_q[0]), 32'd0);

    // Mode 3 short of beats: timeout
    repeat (3) @(negedge i_clk);
    clr_logs();
    push(3'd3);
    wait_op(1, "t5_op_seen");
    for (int b = 0; b < 10; b++) begin
      @(negedge i_clk);
      i_out_valid = 1'b1;
      last_cyc = cyc;
    end
    @(negedge i_clk);
    i_out_valid = 1'b0;
    #3;
    check("t5_err_before", 32'(o_err), 32'd0);
    wait_done(1, "t5_done_seen");
    check("t5_err_timeout", 32'(o_err), 32'd1);
    check("t5_done_mode", 32'(done_q[0]), 32'd3);
    check("t5_timeout_cycles", 32'(done_cyc_q[0] - last_cyc), 32'd256);
    @(negedge i_clk);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    #3;
    check("t5_err_cleared", 32'(o_err), 32'd0);

    // Spurious out beat in IDLE, then reset mid-load
    repeat (3) @(negedge i_clk);
    @(negedge i_clk);
    i_out_valid = 1'b1;
    @(negedge i_clk);
    i_out_valid = 1'b0;
    #3;
    check("t6_err_spur", 32'(o_err), 32'd2);
    clr_logs();
    push(3'd0);
    push(3'd2);
    wait_op(1, "t6_op_seen");
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      i_pix_valid = 1'b1;
      i_pix_data  = 24'(k);
    end
    #3;
    check("t6_busy_mid", 32'(o_busy), 32'd1);
    check("t6_in_valid_mid", 32'(o_in_valid), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #3;
    check("t6_rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("t6_rst_busy", 32'(o_busy), 32'd0);
    check("t6_rst_in_valid", 32'(o_in_valid), 32'd0);
    check("t6_rst_in_data", 32'(o_in_data), 32'd0);
    check("t6_rst_pix_ready", 32'(o_pix_ready), 32'd0);
    check("t6_rst_err", 32'(o_err), 32'd0);
    check("t6_rst_done", 32'(o_done), 32'd0);
    i_pix_valid = 1'b0;
    i_pix_data  = '0;
    @(negedge i_clk);
    clr_logs();
    i_rst_n = 1'b1;
    repeat (20) @(negedge i_clk);
    #3;
    check("t6_fifo_empty_no_op", 32'(op_q.size()), 32'd0);
    check("t6_no_done", 32'(done_q.size()), 32'd0);
    check("t6_busy_after", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
